// File: rtl/pe_adder_tree.sv
// pe_adder_tree: pipelined binary adder tree summing nRowSaInPE unsigned nSaRows-bit lanes.
// Build option PE_INPUT_REG_EN adds a register stage on pe_data_i/valid ahead of the first adder level.
module pe_adder_tree #(
  parameter int nSaRows          = 256,
  parameter int nRowSaInPE       = 4,
  parameter int nStagesAdderTree = 4,
  localparam int peSize          = nRowSaInPE * nSaRows
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                valid,
  input  logic [peSize-1:0]                   pe_data_i,
  output logic [nSaRows+nStagesAdderTree-1:0] pe_data_o,
  output logic                                done_o
);

  // Handshake: valid-only, no ready. Every rising edge with valid=1 accepts pe_data_i;
  // each stage forwards its valid bit every cycle and loads data only when that bit is set.

  localparam int LV = $clog2(nRowSaInPE);
  localparam int OW = nSaRows + nStagesAdderTree;
  localparam int ND = nStagesAdderTree - LV;

  logic [peSize-1:0] src_data;
  logic              src_valid;

`ifdef PE_INPUT_REG_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      src_data  <= '0;
      src_valid <= 1'b0;
    end else begin
      src_valid <= valid;
      if (valid) src_data <= pe_data_i;
    end
  end
`else
  assign src_data  = pe_data_i;
  assign src_valid = valid;
`endif

  // Level j holds nRowSaInPE>>j partial sums, each one bit wider than its inputs.
  for (genvar j = 1; j <= LV; j++) begin : g_lvl
    localparam int IW = nSaRows + j - 1;
    localparam int NW = nSaRows + j;
    localparam int NO = nRowSaInPE >> j;

    logic [2*NO*IW-1:0] in_data;
    logic               in_valid;
    logic [NO*NW-1:0]   sum_d;
    logic [NO*NW-1:0]   sum_q;
    logic               vld_q;

    if (j == 1) begin : g_src
      assign in_data  = src_data;
      assign in_valid = src_valid;
    end else begin : g_prev
      assign in_data  = g_lvl[j-1].sum_q;
      assign in_valid = g_lvl[j-1].vld_q;
    end

    always_comb begin
      sum_d = '0;
      for (int k = 0; k < NO; k++) begin
        sum_d[k*NW +: NW] = NW'(in_data[2*k*IW +: IW]) + NW'(in_data[(2*k+1)*IW +: IW]);
      end
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        sum_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= in_valid;
        if (in_valid) sum_q <= sum_d;
      end
    end
  end

  logic [OW-1:0] tree_data;
  logic          tree_valid;

  assign tree_data  = OW'(g_lvl[LV].sum_q);
  assign tree_valid = g_lvl[LV].vld_q;

  // Stages beyond the adder levels only delay; zero-extension keeps the sum exact.
  if (ND == 0) begin : g_no_dly
    assign pe_data_o = tree_data;
    assign done_o    = tree_valid;
  end else begin : g_dly
    logic [OW-1:0] dly_data [ND];
    logic [ND-1:0] dly_valid;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        for (int s = 0; s < ND; s++) dly_data[s] <= '0;
        dly_valid <= '0;
      end else begin
        dly_valid[0] <= tree_valid;
        if (tree_valid) dly_data[0] <= tree_data;
        for (int s = 1; s < ND; s++) begin
          dly_valid[s] <= dly_valid[s-1];
          if (dly_valid[s-1]) dly_data[s] <= dly_data[s-1];
        end
      end
    end

    assign pe_data_o = dly_data[ND-1];
    assign done_o    = dly_valid[ND-1];
  end

endmodule

// File: tb/tb_pe_adder_tree.sv
// Bench for pe_adder_tree: vector table, hand-written corner sequences and a random stream
// checked every cycle against a history-based reference of the lane-sum pipeline.
module tb_pe_adder_tree;

  localparam int SA = 256;
  localparam int NL = 4;
  localparam int NS = 4;
  localparam int PW = NL * SA;
  localparam int OW = SA + NS;
`ifdef PE_INPUT_REG_EN
  localparam int L = NS + 1;
`else
  localparam int L = NS;
`endif

  logic          clk = 1'b0;
  logic          nrst;
  logic          valid;
  logic [PW-1:0] pe_data_i;
  logic [OW-1:0] pe_data_o;
  logic          done_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: every accepted edge since reset, plus the last result that should be shown.
  logic          hist_v[$];
  logic [OW-1:0] hist_s[$];
  logic [OW-1:0] exp_last;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];

  typedef struct {
    string         name;
    logic [PW-1:0] data;
    logic [OW-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  pe_adder_tree dut (
    .clk       (clk),
    .nrst      (nrst),
    .valid     (valid),
    .pe_data_i (pe_data_i),
    .pe_data_o (pe_data_o),
    .done_o    (done_o)
  );

  // ---------------- model helpers ----------------
  function automatic logic [OW-1:0] ref_sum(input logic [PW-1:0] d);
    logic [OW-1:0] s;
    s = '0;
    for (int k = 0; k < NL; k++) s = s + OW'(d[k*SA +: SA]);
    return s;
  endfunction

  function automatic logic [PW-1:0] rand_data();
    logic [PW-1:0] d;
    for (int w = 0; w < PW/32; w++) d[w*32 +: 32] = $urandom;
    for (int k = 0; k < NL; k++) if ($urandom_range(0, 3) == 0) d[k*SA +: SA] = '1;
    return d;
  endfunction

  task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic [PW-1:0] d);
    int   idx;
    logic exp_done;
    valid     = v;
    pe_data_i = d;
    @(posedge clk);
    if (nrst) begin
      hist_v.push_back(v);
      hist_s.push_back(ref_sum(d));
    end
    #1;
    idx      = hist_v.size() - L;
    exp_done = (idx >= 0) ? hist_v[idx] : 1'b0;
    if (exp_done) exp_last = hist_s[idx];
    chk("done_o", OW'(done_o), OW'(exp_done));
    chk("pe_data_o", pe_data_o, exp_last);
    if (done_o) got_q.push_back(pe_data_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rand_data());
  endtask

  task automatic async_reset();
    #2 nrst = 1'b0;
    hist_v.delete();
    hist_s.delete();
    exp_last = '0;
    #1;
    chk("async_reset_data", pe_data_o, '0);
    chk("async_reset_done", OW'(done_o), '0);
  endtask

  task automatic compare_queues(input string name);
    chk({name, "_count"}, OW'(got_q.size()), OW'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({name, "_order"}, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PW-1:0] d;

    vecs[0].name = "lane0_one";
    vecs[0].data = PW'(1);
    vecs[0].exp  = OW'(1);
    vecs[1].name = "all_ones";
    vecs[1].data = '1;
    vecs[1].exp  = {2'b00, {SA{1'b1}}, 2'b00};
    vecs[2].name = "small_mix";
    vecs[2].data = {SA'(11), SA'(9), SA'(7), SA'(5)};
    vecs[2].exp  = OW'(32);
    vecs[3].name = "msb_pair";
    vecs[3].data = {1'b1, {(SA-1){1'b0}}, 1'b1, {(SA-1){1'b0}}, {(2*SA){1'b0}}};
    vecs[3].exp  = OW'(1) << SA;
    vecs[4].name = "lane3_max";
    vecs[4].data = {{SA{1'b1}}, {(3*SA){1'b0}}};
    vecs[4].exp  = {{(OW-SA){1'b0}}, {SA{1'b1}}};
    vecs[5].name = "zero";
    vecs[5].data = '0;
    vecs[5].exp  = '0;

    nrst      = 1'b0;
    valid     = 1'b0;
    pe_data_i = '0;
    exp_last  = '0;
    #1;
    chk("reset_data_t0", pe_data_o, '0);
    chk("reset_done_t0", OW'(done_o), '0);

    // Reset held with random traffic, then release with no valid
    for (int i = 0; i < 5; i++) cycle(1'($urandom_range(0, 1)), rand_data());
    nrst = 1'b1;
    idle(3);

    // Vector table: one sample each, result checked at the strobe and while held
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vecs[i].data);
      idle(L - 1);
      chk({vecs[i].name, "_strobe"}, OW'(done_o), OW'(1));
      chk({vecs[i].name, "_sum"}, pe_data_o, vecs[i].exp);
      idle(2);
      chk({vecs[i].name, "_hold"}, pe_data_o, vecs[i].exp);
    end

    // Back-to-back 5, 7, 9
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(OW'(5));
    exp_q.push_back(OW'(7));
    exp_q.push_back(OW'(9));
    cycle(1'b1, PW'(5));
    cycle(1'b1, PW'(7));
    cycle(1'b1, PW'(9));
    idle(L + 1);
    compare_queues("b2b");

    // Bubble pattern 1,0,1
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(OW'(20));
    exp_q.push_back(OW'(30));
    cycle(1'b1, PW'(20));
    cycle(1'b0, rand_data());
    cycle(1'b1, PW'(30));
    idle(L + 1);
    compare_queues("bubble");

    // 50-sample back-to-back random stream
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 50; i++) begin
      d = rand_data();
      exp_q.push_back(ref_sum(d));
      cycle(1'b1, d);
    end
    idle(L + 1);
    compare_queues("stream50");

    // Random valid pattern, checked cycle by cycle
    for (int i = 0; i < 40; i++) cycle(1'($urandom_range(0, 1)), rand_data());
    idle(L + 1);

    // Mid-pipeline asynchronous reset discards the in-flight sample
    cycle(1'b1, PW'(77));
    cycle(1'b0, rand_data());
    cycle(1'b0, rand_data());
    async_reset();
    cycle(1'b1, rand_data());
    cycle(1'b0, rand_data());
    nrst = 1'b1;
    got_q.delete();
    idle(L + 2);
    chk("reset_no_done", OW'(got_q.size()), '0);

    // First edge after release accepts
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(OW'(3));
    cycle(1'b1, PW'(3));
    idle(L + 1);
    compare_queues("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
